uart_rx_fifo: RTL and testbench

Serial receive front-end for the SoC UART path. It sits between the board `rxd` pin and the core's UART MMIO consumer. It synchronises and oversamples the line, deframes 8-bit characters, and buffers them in a small FIFO. The FIFO is drained through a valid/ready handshake in the `clk` domain.

---
 rtl/uart_rx_fifo.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling UART receiver feeding a show-ahead byte FIFO
// Define UART_RX_PARITY_EN for 8E1 framing with parity checking; default build is 8N1.
module uart_rx_fifo #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rxd,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   rx_count,
  input  logic                     err_clr,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     parity_err
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_n;
  logic          sync1, rxs;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [3:0]    os;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          start_entry, os_mid, os_end;
  logic          push_req, frame_set;
`ifdef UART_RX_PARITY_EN
  logic          par_set;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  assign tick        = (cnt == CW'(DIV - 1));
  assign start_entry = (state == S_IDLE) && !rxs;
  assign os_mid      = tick && (os == 4'd7);
  assign os_end      = tick && (os == 4'd15);

  // Bit timing restarts at the start edge so every sample lands mid-bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      os      <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      cnt <= (start_entry || tick) ? '0 : cnt + 1'b1;
      if (state == S_IDLE) begin
        os      <= '0;
        bit_idx <= '0;
        par_bad <= 1'b0;
      end else if (tick) begin
        os <= (state == S_START && os == 4'd7) ? 4'd0 : os + 4'd1;
      end
      if (state == S_DATA && os_end) begin
        shreg   <= {rxs, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (state == S_PARITY && os_end)
        par_bad <= (rxs != ^shreg);
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (!rxs) state_n = S_START;
      S_START: if (os_mid) state_n = rxs ? S_IDLE : S_DATA;
      S_DATA: begin
        if (os_end && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (os_end) state_n = S_STOP;
`endif
      S_STOP:  if (os_end) state_n = rxs ? S_IDLE : S_BREAK;
      S_BREAK: if (rxs) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    push_req  = 1'b0;
    frame_set = 1'b0;
    if (state == S_STOP && os_end) begin
      push_req  = rxs && !par_bad;
      frame_set = !rxs;
    end
`ifdef UART_RX_PARITY_EN
    par_set = (state == S_PARITY) && os_end && (rxs != ^shreg);
`endif
  end

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [AW:0] count_n;
  logic        full, pop, wr, ovf_set;

  assign full    = (rx_count == (AW+1)'(DEPTH));
  assign pop     = rx_valid && rx_ready;
  // When full, a same-cycle pop frees the head slot that the write lands in.
  assign wr      = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;
  assign count_n = rx_count + (AW+1)'(wr) - (AW+1)'(pop);
  assign rx_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      rx_count <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (wr) mem[wptr[AW-1:0]] <= shreg;
      wptr     <= wptr + (AW+1)'(wr);
      rptr     <= rptr + (AW+1)'(pop);
      rx_count <= count_n;
      rx_valid <= (count_n != '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set || (frame_err && !err_clr);
      overrun   <= ovf_set || (overrun && !err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) parity_err <= 1'b0;
    else       parity_err <= par_set || (parity_err && !err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue-based frame model
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 16;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT      = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int STOP_START = (9 + NPAR) * BIT;
  // Start edge -> 2 sync flops -> half bit to mid-start -> one bit per remaining sample.
  localparam int PUSH_N = 2 + 8 * DIV + 16 * DIV * (9 + NPAR);

  logic       clk = 1'b0;
  logic       rstn, rxd, rx_ready, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_count;
  logic       frame_err, overrun, parity_err;

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_count(rx_count), .err_clr(err_clr),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q[$];
  bit m_ferr, m_ovr, m_perr;

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    bit         clr;
    int         exp_count;
    bit         exp_ferr;
    logic [7:0] exp_head;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_low, input bit par_flip,
                            input int ready_n, input int abort_n);
    int   total;
    int   b;
    logic lvl;
    total = STOP_START + (stop_low + 1) * BIT;
    for (int n = 0; n < total; n++) begin
      @(negedge clk);
      if (n == abort_n) begin
        rstn = 1'b0;
        rxd = 1'b1;
        rx_ready = 1'b0;
        return;
      end
      b = n / BIT;
      if (b == 0)             lvl = 1'b0;
      else if (b <= 8)        lvl = d[b-1];
      else if (b < 9 + NPAR)  lvl = (^d) ^ par_flip;
      else                    lvl = ((n - STOP_START) < stop_low * BIT) ? 1'b0 : 1'b1;
      rxd = lvl;
      rx_ready = (n == ready_n);
    end
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                             input bit ready_at_push);
    bit popped, was_full;
    popped   = ready_at_push && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    if (popped) void'(q.pop_front());
    if (!par_ok)  m_perr = 1'b1;
    if (!stop_ok) m_ferr = 1'b1;
    if (stop_ok && par_ok) begin
      if (!was_full || popped) q.push_back(d);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic compare_model(input string tag);
    @(negedge clk);
    check({tag, ".count"}, rx_count, q.size());
    check({tag, ".valid"}, rx_valid, q.size() > 0);
    if (q.size() > 0) check({tag, ".head"}, rx_data, q[0]);
    check({tag, ".frame_err"}, frame_err, m_ferr);
    check({tag, ".overrun"}, overrun, m_ovr);
    check({tag, ".parity_err"}, parity_err, m_perr);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    if (q.size() > 0) check({tag, ".pop_data"}, rx_data, q[0]);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clear_flags();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    bit bad;
    int npop;

    vecs[0] = '{data: 8'hA5, stop_low: 0, clr: 1'b0, exp_count: 1, exp_ferr: 1'b0, exp_head: 8'hA5};
    vecs[1] = '{data: 8'h3C, stop_low: 2, clr: 1'b0, exp_count: 1, exp_ferr: 1'b1, exp_head: 8'hA5};
    vecs[2] = '{data: 8'h11, stop_low: 0, clr: 1'b0, exp_count: 2, exp_ferr: 1'b1, exp_head: 8'hA5};
    vecs[3] = '{data: 8'h5A, stop_low: 0, clr: 1'b1, exp_count: 3, exp_ferr: 1'b0, exp_head: 8'hA5};

    rstn = 1'b0; rxd = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    repeat (4) @(negedge clk);
    check("reset.valid", rx_valid, 1'b0);
    check("reset.data", rx_data, 8'h00);
    check("reset.count", rx_count, 5'd0);
    check("reset.flags", {frame_err, overrun, parity_err}, 3'b000);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    compare_model("glitch");

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].clr) clear_flags();
      send_frame(vecs[i].data, vecs[i].stop_low, 1'b0, -1, -1);
      model_frame(vecs[i].data, vecs[i].stop_low == 0, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d.count", i), rx_count, vecs[i].exp_count);
      check($sformatf("vec%0d.frame_err", i), frame_err, vecs[i].exp_ferr);
      check($sformatf("vec%0d.head", i), rx_data, vecs[i].exp_head);
    end

    for (int i = 0; i < 3; i++) pop_check("drain");
    pop_check("empty_pop");
    compare_model("after_drain");

    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 0, 1'b0, -1, -1);
      model_frame(8'(i), 1'b1, 1'b1, 1'b0);
    end
    compare_model("overrun");
    check("overrun.count16", rx_count, 5'd16);
    check("overrun.flag", overrun, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("overrun.pop%0d", i), rx_data, 8'(i));
      pop_check("overrun");
    end
    compare_model("overrun_empty");
    clear_flags();

    for (int i = 0; i < 16; i++) begin
      send_frame(8'(8'h20 + i), 0, 1'b0, -1, -1);
      model_frame(8'(8'h20 + i), 1'b1, 1'b1, 1'b0);
    end
    send_frame(8'h30, 0, 1'b0, PUSH_N, -1);
    model_frame(8'h30, 1'b1, 1'b1, 1'b1);
    compare_model("full_pushpop");
    for (int i = 0; i < 16; i++) pop_check("full_drain");
    compare_model("full_empty");

    for (int i = 0; i < 10; i++) begin
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) pop_check("rnd");
      if ($urandom_range(0, 4) == 0) clear_flags();
      bad = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      send_frame(d, bad ? 1 : 0, 1'b0, -1, -1);
      model_frame(d, !bad, 1'b1, 1'b0);
      compare_model($sformatf("rnd%0d", i));
    end

    send_frame(8'h99, 0, 1'b0, -1, 5 * BIT + BIT / 2);
    q.delete();
    m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    @(negedge clk);
    check("midreset.valid", rx_valid, 1'b0);
    check("midreset.data", rx_data, 8'h00);
    check("midreset.count", rx_count, 5'd0);
    check("midreset.flags", {frame_err, overrun, parity_err}, 3'b000);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hC3, 0, 1'b0, -1, -1);
    model_frame(8'hC3, 1'b1, 1'b1, 1'b0);
    compare_model("after_reset");
    check("after_reset.data", rx_data, 8'hC3);

`ifdef UART_RX_PARITY_EN
    pop_check("par_pre");
    send_frame(8'h07, 0, 1'b1, -1, -1);
    model_frame(8'h07, 1'b1, 1'b0, 1'b0);
    compare_model("parity");
    check("parity.flag", parity_err, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
